// File: rtl/div_core_arbiter.sv
// div_core_arbiter: shares one iterative unsigned divider between NUM_REQ
// requesters. Round-robin grant in IDLE, operands held in registers while the
// divider runs, result returned to the owner with a valid/ack handshake.
module div_core_arbiter #(
  parameter  int NUM_REQ   = 2,
  parameter  int DIV_WIDTH = 32,
  localparam int CW        = $clog2(DIV_WIDTH),
  localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIV_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DIV_WIDTH-1:0] req_divisor,
  input  logic [NUM_REQ*CW-1:0]     req_dividend_clz,
  input  logic [NUM_REQ*CW-1:0]     req_divisor_clz,
  input  logic [NUM_REQ-1:0]        req_divisor_is_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DIV_WIDTH-1:0]      rsp_quotient,
  output logic [DIV_WIDTH-1:0]      rsp_remainder,
  input  logic [NUM_REQ-1:0]        rsp_ack,
  output logic                      div_start,
  output logic [DIV_WIDTH-1:0]      div_dividend,
  output logic [DIV_WIDTH-1:0]      div_divisor,
  output logic [CW-1:0]             div_dividend_clz,
  output logic [CW-1:0]             div_divisor_clz,
  output logic                      div_divisor_is_zero,
  input  logic                      div_done,
  input  logic [DIV_WIDTH-1:0]      div_quotient,
  input  logic [DIV_WIDTH-1:0]      div_remainder
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BUSY, S_RESP, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        rr_ptr_q, owner_q;
  logic [DIV_WIDTH-1:0] dvd_q, dvs_q, quo_q, rem_q;
  logic [CW-1:0]        dvd_clz_q, dvs_clz_q;
  logic                 dz_q;

  logic                 hi_found, lo_found, grant_found;
  logic [OW-1:0]        hi_idx, lo_idx, grant_idx, rr_next;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 accept, latch_rsp;
  logic [DIV_WIDTH-1:0] sel_dvd, sel_dvs;
  logic [CW-1:0]        sel_dvd_clz, sel_dvs_clz;
  logic                 sel_dz;

  // Round-robin pick: lowest valid index at/after rr_ptr, else lowest valid overall.
  // Descending scan so the last hit is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = OW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = OW'(i);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
    rr_next     = (grant_idx == OW'(NUM_REQ-1)) ? '0 : grant_idx + OW'(1);
  end

  // Operand mux for the candidate requester and one-hot form of its index.
  always_comb begin
    sel_dvd     = '0;
    sel_dvs     = '0;
    sel_dvd_clz = '0;
    sel_dvs_clz = '0;
    sel_dz      = 1'b0;
    gnt_oh      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == OW'(i)) begin
        gnt_oh[i]   = 1'b1;
        sel_dvd     = req_dividend[i*DIV_WIDTH +: DIV_WIDTH];
        sel_dvs     = req_divisor[i*DIV_WIDTH +: DIV_WIDTH];
        sel_dvd_clz = req_dividend_clz[i*CW +: CW];
        sel_dvs_clz = req_divisor_clz[i*CW +: CW];
        sel_dz      = req_divisor_is_zero[i];
      end
    end
  end

  // Result valid goes only to the owner while in RESP.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = (state_q == S_RESP) && (owner_q == OW'(i));
  end

  // FSM next state and handshake outputs; flush outranks every other event.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    div_start = 1'b0;
    accept    = 1'b0;
    latch_rsp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && !rst && grant_found) req_ready = gnt_oh;
        accept = |(req_ready & req_valid);
        if (accept) state_d = S_START;
      end
      S_START: begin
        if (flush) state_d = S_IDLE;
        else begin
          div_start = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // div_core cannot abort: a flush before completion must drain it.
        if (flush) state_d = div_done ? S_IDLE : S_DRAIN;
        else if (div_done) begin
          latch_rsp = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || (|(rsp_ack & rsp_valid))) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (div_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, round-robin pointer, owner, operand hold and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvd_clz_q <= '0;
      dvs_clz_q <= '0;
      dz_q      <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q   <= grant_idx;
        rr_ptr_q  <= rr_next;
        dvd_q     <= sel_dvd;
        dvs_q     <= sel_dvs;
        dvd_clz_q <= sel_dvd_clz;
        dvs_clz_q <= sel_dvs_clz;
        dz_q      <= sel_dz;
      end
      if (latch_rsp) begin
        quo_q <= div_quotient;
        rem_q <= div_remainder;
      end
    end
  end

  assign rsp_quotient        = quo_q;
  assign rsp_remainder       = rem_q;
  assign div_dividend        = dvd_q;
  assign div_divisor         = dvs_q;
  assign div_dividend_clz    = dvd_clz_q;
  assign div_divisor_clz     = dvs_clz_q;
  assign div_divisor_is_zero = dz_q;

endmodule

// File: tb/tb_div_core_arbiter.sv
// Bench for div_core_arbiter: behavioural divider model plus a scoreboard of
// expected results pushed at grant time and popped when rsp_valid appears.
module tb_div_core_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ack, req_divisor_is_zero;
  logic [N*W-1:0]  req_dividend, req_divisor;
  logic [N*CW-1:0] req_dividend_clz, req_divisor_clz;
  logic [W-1:0]    rsp_quotient, rsp_remainder;
  logic            div_start, div_divisor_is_zero;
  logic [W-1:0]    div_dividend, div_divisor;
  logic [CW-1:0]   div_dividend_clz, div_divisor_clz;
  logic            div_done = 1'b0;
  logic [W-1:0]    div_quotient = '0, div_remainder = '0;

  typedef struct {int owner; logic [W-1:0] q; logic [W-1:0] r;} exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int div_lat = 3;
  int cnt = 0, start_cnt = 0;
  logic busy_viol = 1'b0;
  logic [W-1:0] mq = '0, mr = '0;

  always #5 clk = ~clk;

  div_core_arbiter #(.NUM_REQ(N), .DIV_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_dividend_clz(req_dividend_clz), .req_divisor_clz(req_divisor_clz),
    .req_divisor_is_zero(req_divisor_is_zero),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_ack(rsp_ack), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_dividend_clz(div_dividend_clz), .div_divisor_clz(div_divisor_clz),
    .div_divisor_is_zero(div_divisor_is_zero),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // Iterative divider model: fixed latency, one-cycle done pulse.
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (rst) cnt <= 0;
    else begin
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          div_done      <= 1'b1;
          div_quotient  <= mq;
          div_remainder <= mr;
        end
      end
      if (div_start) begin
        if (cnt != 0) busy_viol <= 1'b1;
        cnt       <= div_lat;
        mq        <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
        mr        <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        start_cnt <= start_cnt + 1;
      end
    end
  end

  function automatic logic [CW-1:0] clz32(input logic [W-1:0] x);
    for (int k = W-1; k >= 0; k--) if (x[k]) return CW'(W-1-k);
    return CW'(W-1);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W]      = a;
    req_divisor[i*W +: W]       = b;
    req_dividend_clz[i*CW +: CW] = clz32(a);
    req_divisor_clz[i*CW +: CW]  = clz32(b);
    req_divisor_is_zero[i]      = (b == 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk({tag, ".rst_out"}, {req_ready, rsp_valid, div_start}, '0);
  endtask

  // Wait for an accept, check the grant, queue the expected result, then check START.
  task automatic grant(input int exp_owner, input bit flush_start, input string tag);
    int k;
    logic [W-1:0] a, b;
    k = 0;
    #1;
    while (!(|(req_ready & req_valid)) && k < 40) begin @(negedge clk); #1; k++; end
    chk({tag, ".grant"}, req_ready, oh(exp_owner));
    a = req_dividend[exp_owner*W +: W];
    b = req_divisor[exp_owner*W +: W];
    sb.push_back('{exp_owner, (b == 0) ? '1 : a / b, (b == 0) ? a : a % b});
    @(negedge clk);
    if (flush_start) flush = 1'b1;
    #1;
    chk({tag, ".start"}, div_start, !flush_start);
    chk({tag, ".ready_start"}, req_ready, '0);
    if (!flush_start) begin
      chk({tag, ".opnd"}, {div_dividend, div_divisor}, {a, b});
      chk({tag, ".clz"}, {div_dividend_clz, div_divisor_clz, div_divisor_is_zero},
          {clz32(a), clz32(b), b == 0});
    end
  endtask

  // Wait for div_done, check the response one cycle later, hold it, then ack or flush.
  task automatic wait_rsp(input int ack_delay, input bit flush_resp, input string tag);
    exp_t e;
    int k, s0;
    k = 0;
    while (!div_done && k < 60) begin @(negedge clk); #1; k++; end
    chk({tag, ".done"}, div_done, 1);
    chk({tag, ".pre"}, rsp_valid, '0);
    @(negedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".vld"}, rsp_valid, oh(e.owner));
    chk({tag, ".qr"}, {rsp_quotient, rsp_remainder}, {e.q, e.r});
    s0 = start_cnt;
    for (int j = 0; j < ack_delay; j++) begin
      rsp_ack = ~oh(e.owner);
      @(negedge clk); #1;
      chk({tag, ".hold_v"}, {rsp_valid, req_ready}, {oh(e.owner), {N{1'b0}}});
      chk({tag, ".hold_qr"}, {rsp_quotient, rsp_remainder}, {e.q, e.r});
    end
    if (flush_resp) begin rsp_ack = '0; flush = 1'b1; end
    else rsp_ack = oh(e.owner);
    @(negedge clk);
    flush = 1'b0; rsp_ack = '0; #1;
    chk({tag, ".drop"}, rsp_valid, '0);
    if (ack_delay > 0) chk({tag, ".nostart"}, start_cnt, s0);
  endtask

  initial begin : wdog
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int s0, k;
    rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ack = '0;
    req_dividend = '0; req_divisor = '0; req_dividend_clz = '0;
    req_divisor_clz = '0; req_divisor_is_zero = '0;
    do_reset("t0");

    // 1. single op 100/7 -> q=14 r=2
    set_op(0, 100, 7); req_valid = 2'b01;
    grant(0, 0, "t1");
    req_valid = '0;
    wait_rsp(0, 0, "t1");

    // 2+3. contention from reset: grants alternate; op1 backpressured with non-owner ack
    do_reset("t2");
    set_op(0, 1000, 10); set_op(1, 77, 5); req_valid = 2'b11;
    grant(0, 0, "t2.op0"); set_op(0, 32'hFFFF_FFFF, 0); wait_rsp(0, 0, "t2.op0");
    grant(1, 0, "t2.op1"); set_op(1, 12345, 123);       wait_rsp(10, 0, "t3.op1");
    grant(0, 0, "t2.op2");                              wait_rsp(0, 0, "t2.op2");
    grant(1, 0, "t2.op3"); req_valid = '0;              wait_rsp(0, 0, "t2.op3");

    // 4. flush in BUSY -> DRAIN; late done produces nothing; next request served
    div_lat = 6;
    set_op(0, 50, 3); req_valid = 2'b01;
    grant(0, 0, "t4");
    req_valid = '0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; set_op(1, 9, 4); req_valid = 2'b10; #1;
    chk("t4.drain_ready", req_ready, '0);
    k = 0;
    while (!div_done && k < 60) begin @(negedge clk); #1; k++; end
    chk("t4.late_done", div_done, 1);
    chk("t4.no_rsp_done", {rsp_valid, req_ready}, '0);
    void'(sb.pop_front());
    @(negedge clk); #1;
    chk("t4.no_rsp_after", rsp_valid, '0);
    div_lat = 3;
    grant(1, 0, "t4.next");
    req_valid = '0;
    wait_rsp(0, 0, "t4.next");

    // 5a. flush in START -> no div_start pulse
    s0 = start_cnt;
    set_op(0, 20, 6); req_valid = 2'b01;
    grant(0, 1, "t5s");
    req_valid = '0;
    void'(sb.pop_front());
    @(negedge clk); flush = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t5s.nostart", start_cnt, s0);
    chk("t5s.idle", {rsp_valid, div_done}, '0);

    // 5b. flush in RESP -> rsp_valid drops next cycle
    set_op(1, 81, 9); req_valid = 2'b10;
    grant(1, 0, "t5r");
    req_valid = '0;
    wait_rsp(2, 1, "t5r");

    // 6. reset in BUSY -> outputs clear, rr_ptr back to 0
    set_op(0, 40, 8); req_valid = 2'b01;
    grant(0, 0, "t6");
    req_valid = '0;
    void'(sb.pop_front());
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t6.rst_out", {req_ready, rsp_valid, div_start}, '0);
    set_op(0, 60, 7); set_op(1, 33, 4); req_valid = 2'b11;
    grant(0, 0, "t6.first");
    wait_rsp(0, 0, "t6.first");
    grant(1, 0, "t6.second");
    req_valid = '0;
    wait_rsp(0, 0, "t6.second");

    chk("busy_start", busy_viol, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
